// File: rtl/biquad_pkg.sv
// Shared definitions for the time-shared biquad scheduler.
// Contents:
//   state_t         scheduler FSM states
//   COEF_B0..A2     coefficient-select encodings (cfg_sel)
//   acc_width()     width of the signed MAC accumulator for a given sample width
//   sat_dw()        clamp a wide signed value into the signed range of dw bits
package biquad_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC0,
        S_MAC1,
        S_MAC2,
        S_MAC3,
        S_MAC4,
        S_NORM,
        S_OUT
    } state_t;

    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;
    localparam int NCOEF = 5;

    // Working width for saturation; must exceed acc_width(DW), so DW <= 62.
    localparam int SAT_W = 128;

    // Five DW x DW products summed need 2*DW+3 bits to never wrap.
    function automatic int acc_width(input int dw);
        return 2 * dw + 3;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] v,
                                                       input int dw);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (dw - 1)) - one;
        lo  = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/biquad_tdm_sched_rr_arbiter.sv
// Round-robin arbiter (purely combinational).
// Ports:
//   req        N request lines
//   ptr        index where the search starts (highest priority this round)
//   grant      one-hot grant of the first active request at or after ptr
//   grant_idx  binary index of the granted request (0 when nothing is granted)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            // ptr < N always, so a single wrap keeps idx in range
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/biquad_tdm_sched.sv
// Time-division biquad scheduler: one serial MAC shared by NCH channels.
// A round-robin winner is accepted in IDLE, its coefficients and delay line are
// snapshotted, five products are accumulated (one per cycle), the sum is shifted
// and saturated, the channel's delay line is updated and the result is held on
// out_* until the consumer takes it.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_data/in_ready    per-channel sample handshake (one-hot ready)
//   out_valid/out_ready          result handshake
//   out_ch/out_data              channel tag and saturated y(n)
//   cfg_we/cfg_ch/cfg_sel/cfg_data  coefficient write (sel 0..4 = b0,b1,b2,a1,a2)
//   cfg_clr                      clear x1,x2,y1,y2 of cfg_ch
//   busy                         FSM not in IDLE
//
// state  | meaning
// IDLE   | waiting for a request; in_ready follows the arbiter
// MAC0-4 | accumulate b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2
// NORM   | shift/saturate into out_data, write back delay line
// OUT    | result presented until out_ready
module biquad_tdm_sched
    import biquad_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 32,
    parameter int SHIFT = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH-1:0]            in_valid,
    input  logic [NCH*DW-1:0]         in_data,
    output logic [NCH-1:0]            in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(NCH)-1:0]    out_ch,
    output logic signed [DW-1:0]      out_data,
    input  logic                      cfg_we,
    input  logic [$clog2(NCH)-1:0]    cfg_ch,
    input  logic [2:0]                cfg_sel,
    input  logic signed [DW-1:0]      cfg_data,
    input  logic                      cfg_clr,
    output logic                      busy
);

    localparam int CW   = $clog2(NCH);
    localparam int ACCW = acc_width(DW);
    localparam int PW   = 2 * DW;

    state_t state, state_nxt;

    logic [CW-1:0]          ptr, gidx, ch_r;
    logic [NCH-1:0]         grant;
    logic                   accept;
    logic                   cfg_hit;

    logic signed [DW-1:0]   coef [NCH][NCOEF];
    logic signed [DW-1:0]   x1_m [NCH];
    logic signed [DW-1:0]   x2_m [NCH];
    logic signed [DW-1:0]   y1_m [NCH];
    logic signed [DW-1:0]   y2_m [NCH];

    logic signed [DW-1:0]   s_coef [NCOEF];
    logic signed [DW-1:0]   s_x, s_x1, s_x2, s_y1, s_y2;

    logic signed [DW-1:0]   op_c, op_d;
    logic                   op_sub;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext, acc, acc_shr;
    logic signed [SAT_W-1:0] y_wide;
    logic signed [DW-1:0]   y_sat;

    rr_arbiter #(.N(NCH), .CW(CW)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (gidx)
    );

    // Gated by rst_n so no request is acknowledged while reset is held.
    assign in_ready  = (state == S_IDLE && rst_n) ? grant : '0;
    assign accept    = |(in_valid & in_ready);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_OUT);
    assign out_ch    = ch_r;
    assign cfg_hit   = (int'(cfg_ch) < NCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_MAC0;
            S_MAC0:  state_nxt = S_MAC1;
            S_MAC1:  state_nxt = S_MAC2;
            S_MAC2:  state_nxt = S_MAC3;
            S_MAC3:  state_nxt = S_MAC4;
            S_MAC4:  state_nxt = S_NORM;
            S_NORM:  state_nxt = S_OUT;
            S_OUT:   if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        op_c   = s_coef[COEF_B0];
        op_d   = s_x;
        op_sub = 1'b0;
        case (state)
            S_MAC1: begin op_c = s_coef[COEF_B1]; op_d = s_x1; end
            S_MAC2: begin op_c = s_coef[COEF_B2]; op_d = s_x2; end
            S_MAC3: begin op_c = s_coef[COEF_A1]; op_d = s_y1; op_sub = 1'b1; end
            S_MAC4: begin op_c = s_coef[COEF_A2]; op_d = s_y2; op_sub = 1'b1; end
            default: ;
        endcase
    end

    assign prod     = op_c * op_d;
    assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
    assign acc_shr  = acc >>> SHIFT;
    assign y_wide   = sat_dw({{(SAT_W-ACCW){acc_shr[ACCW-1]}}, acc_shr}, DW);
    assign y_sat    = y_wide[DW-1:0];

    // Snapshot, pointer, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            ch_r     <= '0;
            out_data <= '0;
            acc      <= '0;
            s_x      <= '0;
            s_x1     <= '0;
            s_x2     <= '0;
            s_y1     <= '0;
            s_y2     <= '0;
            for (int k = 0; k < NCOEF; k++) s_coef[k] <= '0;
        end else begin
            if (accept) begin
                ch_r <= gidx;
                ptr  <= (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
                s_x  <= in_data[gidx*DW +: DW];
                s_x1 <= x1_m[gidx];
                s_x2 <= x2_m[gidx];
                s_y1 <= y1_m[gidx];
                s_y2 <= y2_m[gidx];
                for (int k = 0; k < NCOEF; k++) s_coef[k] <= coef[gidx][k];
            end
            case (state)
                S_MAC0:                         acc <= prod_ext;
                S_MAC1, S_MAC2, S_MAC3, S_MAC4: acc <= op_sub ? acc - prod_ext : acc + prod_ext;
                S_NORM:                         out_data <= y_sat;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                for (int k = 0; k < NCOEF; k++) coef[i][k] <= '0;
            end
        end else if (cfg_we && cfg_hit && cfg_sel <= COEF_A2) begin
            coef[cfg_ch][cfg_sel] <= cfg_data;
        end
    end

    // Delay-line bank. The clear is placed after the writeback so that a clear
    // of the active channel during NORM wins over the update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                x1_m[i] <= '0;
                x2_m[i] <= '0;
                y1_m[i] <= '0;
                y2_m[i] <= '0;
            end
        end else begin
            if (state == S_NORM) begin
                x2_m[ch_r] <= s_x1;
                x1_m[ch_r] <= s_x;
                y2_m[ch_r] <= s_y1;
                y1_m[ch_r] <= y_sat;
            end
            if (cfg_clr && cfg_hit) begin
                x1_m[cfg_ch] <= '0;
                x2_m[cfg_ch] <= '0;
                y1_m[cfg_ch] <= '0;
                y2_m[cfg_ch] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_biquad_tdm_sched.sv
// Self-checking bench for biquad_tdm_sched (NCH=4, DW=32, SHIFT=7).
// A transaction-level model predicts in_ready, out_valid, busy, out_ch and
// out_data every cycle; directed tests add literal expectations.
// SHIFT=0 scenarios are expressed with coefficients scaled by 128.
module tb_biquad_tdm_sched;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int SHIFT = 7;
    localparam int CW    = 2;
    localparam longint YMAX = (64'sd1 <<< (DW - 1)) - 1;
    localparam longint YMIN = -YMAX - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NCH-1:0]         in_valid = '0;
    logic [NCH*DW-1:0]      in_data = '0;
    logic [NCH-1:0]         in_ready;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [CW-1:0]          out_ch;
    logic signed [DW-1:0]   out_data;
    logic                   cfg_we = 1'b0;
    logic [CW-1:0]          cfg_ch = '0;
    logic [2:0]             cfg_sel = '0;
    logic signed [DW-1:0]   cfg_data = '0;
    logic                   cfg_clr = 1'b0;
    logic                   busy;

    always #5 clk = ~clk;

    biquad_tdm_sched #(.NCH(NCH), .DW(DW), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .cfg_clr   (cfg_clr),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int n_out  = 0;
    logic [NCH-1:0] hs_vec = '0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic signed [DW-1:0] m_coef [NCH][5];
    logic signed [DW-1:0] m_x1 [NCH];
    logic signed [DW-1:0] m_x2 [NCH];
    logic signed [DW-1:0] m_y1 [NCH];
    logic signed [DW-1:0] m_y2 [NCH];
    int  m_ptr  = 0;
    bit  m_busy = 0;
    int  m_k    = 0;
    int  m_ch   = 0;
    logic signed [DW-1:0] m_y = '0;
    logic signed [DW-1:0] w_x1, w_x2, w_y1, w_y2;

    function automatic logic signed [DW-1:0] ref_y(
        input logic signed [DW-1:0] b0, b1, b2, a1, a2, x, x1, x2, y1, y2);
        logic signed [127:0] t [10];
        logic signed [127:0] s;
        logic signed [DW-1:0] r;
        t[0] = b0; t[1] = b1; t[2] = b2; t[3] = a1; t[4] = a2;
        t[5] = x;  t[6] = x1; t[7] = x2; t[8] = y1; t[9] = y2;
        s = t[0]*t[5] + t[1]*t[6] + t[2]*t[7] - t[3]*t[8] - t[4]*t[9];
        s = s >>> SHIFT;
        if (s > YMAX) s = YMAX;
        if (s < YMIN) s = YMIN;
        r = s[DW-1:0];
        return r;
    endfunction

    function automatic int winner();
        for (int i = 0; i < NCH; i++) begin
            if (in_valid[(m_ptr + i) % NCH]) return (m_ptr + i) % NCH;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ptr = 0; m_busy = 0; m_k = 0; m_ch = 0;
            for (int i = 0; i < NCH; i++) begin
                for (int k = 0; k < 5; k++) m_coef[i][k] = '0;
                m_x1[i] = '0; m_x2[i] = '0; m_y1[i] = '0; m_y2[i] = '0;
            end
        end else begin
            if (m_busy) begin
                if (m_k >= 6 && out_ready) begin
                    m_busy = 0;
                end else begin
                    m_k++;
                    if (m_k == 6) begin
                        m_x1[m_ch] = w_x1; m_x2[m_ch] = w_x2;
                        m_y1[m_ch] = w_y1; m_y2[m_ch] = w_y2;
                    end
                end
            end else begin
                int g;
                logic signed [DW-1:0] x;
                g = winner();
                if (g >= 0) begin
                    x    = in_data[g*DW +: DW];
                    m_ch = g;
                    m_y  = ref_y(m_coef[g][0], m_coef[g][1], m_coef[g][2], m_coef[g][3],
                                 m_coef[g][4], x, m_x1[g], m_x2[g], m_y1[g], m_y2[g]);
                    w_x1 = x; w_x2 = m_x1[g]; w_y1 = m_y; w_y2 = m_y1[g];
                    m_busy = 1; m_k = 0;
                    m_ptr  = (g + 1) % NCH;
                end
            end
            if (cfg_we && cfg_sel < 3'd5) m_coef[cfg_ch][cfg_sel] = cfg_data;
            if (cfg_clr) begin
                m_x1[cfg_ch] = '0; m_x2[cfg_ch] = '0; m_y1[cfg_ch] = '0; m_y2[cfg_ch] = '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic [NCH-1:0] exp_ir;
        bit exp_ov;
        int g;
        @(negedge clk);
        hs_vec = in_valid & in_ready;
        exp_ir = '0;
        if (rst_n && !m_busy) begin
            g = winner();
            if (g >= 0) exp_ir[g] = 1'b1;
        end
        exp_ov = rst_n && m_busy && (m_k >= 6);
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        chk("busy", busy, m_busy);
        if (exp_ov) begin
            chk("out_ch", out_ch, m_ch);
            chk("out_data", out_data, m_y);
            if (out_ready) n_out++;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic cfg_wr(input int ch, input int sel, input logic signed [DW-1:0] val);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = 3'(sel); cfg_data = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_clear(input int ch);
        cfg_clr = 1'b1; cfg_ch = CW'(ch);
        @(posedge clk); #1;
        cfg_clr = 1'b0;
    endtask

    task automatic send(input int ch, input logic signed [DW-1:0] x);
        bit ok;
        ok = 0;
        in_data[ch*DW +: DW] = x;
        in_valid[ch] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (hs_vec[ch]) begin ok = 1; break; end
        end
        in_valid[ch] = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    task automatic send_expect(input int ch, input logic signed [DW-1:0] x,
                               input logic signed [DW-1:0] exp, input bit pin,
                               input string tag);
        int n;
        bit seen;
        send(ch, x);
        n = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) begin seen = 1; break; end
        end
        chk({tag, "_latency"}, n, 6);
        if (seen && pin) begin
            chk({tag, "_data"}, out_data, exp);
            chk({tag, "_ch"}, out_ch, ch);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic signed [DW-1:0] rnd_sample();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return DW'(int'($urandom_range(0, 40000)) - 20000);
    endfunction

    // ---------------- main sequence ----------------
    int order [4];
    int lpf_pin [3] = '{1015, 3800, 6613};
    int ov_cnt;

    initial begin
        in_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_data", out_data, 0);
        in_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // passthrough (b0 = 1.0)
        cfg_wr(0, 0, 128);
        send_expect(0, 10000, 10000, 1, "pass0");
        send_expect(0, 20000, 20000, 1, "pass1");

        // delay and feedback: b0 = 1, a1 = -1
        cfg_wr(1, 0, 128);
        cfg_wr(1, 3, -128);
        send_expect(1, 5, 5, 1, "fb0");
        send_expect(1, 5, 10, 1, "fb1");
        send_expect(1, 5, 15, 1, "fb2");
        cfg_clear(1);
        send_expect(1, 5, 5, 1, "fb_clr");

        // reference lowpass step response
        cfg_wr(2, 0, 13);
        cfg_wr(2, 1, 26);
        cfg_wr(2, 2, 13);
        cfg_wr(2, 3, -95);
        cfg_wr(2, 4, 34);
        for (int i = 0; i < 20; i++) begin
            send_expect(2, 10000, (i < 3) ? lpf_pin[i] : 0, i < 3, "lpf");
        end

        // saturation, and the saturated value is what feeds back
        cfg_wr(3, 0, 512);
        send_expect(3, 32'sh40000000, 32'sh7FFFFFFF, 1, "sat_pos");
        send_expect(3, 32'shC0000000, 32'sh80000000, 1, "sat_neg");
        cfg_wr(3, 0, 0);
        cfg_wr(3, 3, -64);
        send_expect(3, 0, 32'shC0000000, 1, "sat_y1");

        // arbitration order and backpressure on ch1
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) cfg_wr(c, 0, 128);
        fork
            send(0, 100);
            send(1, 200);
            send(2, 300);
            send(3, 400);
            begin
                for (int r = 0; r < 4; r++) begin
                    for (int i = 0; i < 100; i++) begin
                        @(posedge clk); #1;
                        if (out_valid) break;
                    end
                    order[r] = int'(out_ch);
                    if (out_ch == 2'd1) begin
                        out_ready = 1'b0;
                        for (int i = 0; i < 10; i++) begin
                            @(negedge clk);
                            chk("bp_data", out_data, 200);
                            chk("bp_ch", out_ch, 1);
                            chk("bp_in_ready", in_ready, 0);
                        end
                        @(posedge clk); #1;
                        out_ready = 1'b1;
                    end
                    @(posedge clk); #1;
                end
            end
        join
        for (int r = 0; r < 4; r++) chk("grant_order", order[r], r);

        // reset in MAC2 discards the sample and clears coefficients/state
        cfg_wr(2, 0, 128);
        send(2, 777);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mac2_busy", busy, 1);
        rst_n = 1'b0;
        ov_cnt = 0;
        repeat (3) begin @(negedge clk); ov_cnt += int'(out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); ov_cnt += int'(out_valid); end
        chk("reset_no_out", ov_cnt, 0);
        @(posedge clk); #1;
        send_expect(2, 1000, 0, 1, "post_rst2");
        send_expect(0, 5000, 0, 1, "post_rst0");

        // randomized traffic, config writes and clears against the model
        ov_cnt = n_out;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (in_valid[c] && hs_vec[c]) begin
                    in_valid[c] = 1'b0;
                end else if (in_valid[c]) begin
                    if ($urandom_range(0, 99) < 2) in_valid[c] = 1'b0;
                end else if ($urandom_range(0, 99) < 25) begin
                    in_valid[c] = 1'b1;
                    in_data[c*DW +: DW] = rnd_sample();
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            cfg_we    = ($urandom_range(0, 99) < 6);
            cfg_ch    = CW'($urandom_range(0, NCH - 1));
            cfg_sel   = 3'($urandom_range(0, 7));
            cfg_data  = DW'(int'($urandom_range(0, 256)) - 128);
            cfg_clr   = ($urandom_range(0, 99) < 3);
            @(posedge clk); #1;
        end
        in_valid = '0; cfg_we = 1'b0; cfg_clr = 1'b0; out_ready = 1'b1;
        repeat (30) @(posedge clk);
        chk("random_traffic", (n_out - ov_cnt) > 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/biquad_tdm_sched.md
Name: biquad_tdm_sched

Overview:
- Time-division scheduler that shares one serial multiply-accumulate biquad engine between NCH independent sample channels.
- Arbitrates per-channel input requests round-robin and snapshots that channel's coefficient bank and delay-line state.
- Sequences five MAC steps, normalises and saturates the result, then presents it on a single output stream tagged with the channel number.
- Sits between the sample sources and the downstream consumer. It replaces per-channel lpf instances when area matters.

Parameters:
- NCH, 4, number of channels (2..16).
- DW, 32, signed sample and coefficient width.
- SHIFT, 7, arithmetic right shift applied to the accumulator (implicit a0 = 2^SHIFT).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NCH  per-channel sample request.
- in_data  in  NCH*DW  per-channel signed samples; channel i occupies [i*DW +: DW].
- in_ready  out  NCH  one-hot accept; a transfer occurs when in_valid[i] & in_ready[i].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_ch  out  clog2(NCH)  channel of the result.
- out_data  out  DW  signed, saturated y(n).
- cfg_we  in  1  coefficient write strobe.
- cfg_ch  in  clog2(NCH)  target channel.
- cfg_sel  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; values 5..7 are ignored.
- cfg_data  in  DW  coefficient value, signed.
- cfg_clr  in  1  clears x1, x2, y1, y2 of channel cfg_ch.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Equation: y = sat_DW((b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> SHIFT).
  - Accumulator is signed, 2*DW+3 bits wide.
  - Shift is arithmetic (floor).
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- Reset (async assert, sync deassert):
  - FSM goes to IDLE; in_ready, out_valid, busy, out_ch and out_data are all 0.
  - Round-robin pointer goes to 0.
  - All coefficients and all delay-line state are cleared to 0.
- FSM states: IDLE, MAC0..MAC4, NORM, OUT.
- IDLE:
  - If any in_valid is high, in_ready[g] is driven combinationally for the round-robin winner g. The search starts at the pointer.
  - On the accept edge the block latches x, the channel index, the five coefficients and x1/x2/y1/y2 of channel g.
  - It then moves to MAC0 and sets pointer = g+1 mod NCH.
  - in_ready is 0 in every other state.
- MACk (k = 0..4): one product per cycle, in the order b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2.
- NORM: shift and saturate into out_data. Write back channel g's state: x2←x1, x1←x, y2←y1, y1←y(saturated). Move to OUT.
- OUT: out_valid=1 and out_ch=g. out_data and out_ch stay stable until out_valid & out_ready, then return to IDLE.
- Timing:
  - out_valid rises on the 6th rising edge after the accept edge.
  - Minimum spacing between accepts is 8 cycles.
- Config timing:
  - cfg writes take effect at the clock edge, in any state.
  - Because the snapshot is taken at accept, a write to the active channel affects only its next sample.
- cfg_clr:
  - Takes effect in any state.
  - If it targets the active channel in the NORM cycle, clear wins and the writeback is suppressed. The current result is still output.
- Simultaneous cfg_we and cfg_clr on the same channel: both take effect.
- Reset mid-operation: the in-flight sample is discarded and no out_valid is produced.
- Sources must hold in_valid and in_data until accepted. Dropping in_valid before acceptance withdraws the request with no side effect.

Decomposition:
- Package biquad_pkg holds:
  - the state enum;
  - coefficient-select encodings COEF_B0..COEF_A2;
  - the accumulator width function;
  - the saturation function.
- One sub-module: rr_arbiter (NCH requests, pointer, one-hot grant, combinational).
- MAC, coefficient bank and state bank stay in the top module.

Test Plan:
- Passthrough: SHIFT=0, ch0 b0=1 and all other coefficients 0; send x=10000 then 20000 → out_data 10000 then 20000, out_ch=0, out_valid on the 6th edge after each accept.
- Delay and feedback: SHIFT=0, ch1 b0=1, a1=-1; send 5, 5, 5 → 5, 10, 15. Then cfg_clr ch1 and send 5 → 5.
- Reference lowpass: SHIFT=7, b=13,26,13, a1=-95, a2=34 (values scaled to /128); step input 10000 → output matches a golden model bit-exactly for 20 samples.
- Saturation: SHIFT=0, b0=4; send x=2^30 → 0x7FFFFFFF. Send x=-2^30 → 0x80000000. The stored y1 is the saturated value.
- Arbitration and backpressure: all four channels valid after reset → grants in order 0,1,2,3. Hold out_ready=0 for 10 cycles during ch1's result → out_data and out_ch stay stable, no in_ready, no loss.
- Reset mid-MAC: assert rst_n=0 in MAC2 → out_valid stays 0, coefficients and state read back as zero, next sample yields 0.
